// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the fetch PC, requests the shared instruction
// memory port and buffers fetched words in a small prefetch FIFO for decode.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned CNT_W    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_rdata,
   output logic             imem_req,
   input  logic             imem_gnt,
   output logic             if_valid,
   output logic [31:0]      if_instr,
   output logic [31:0]      if_pc,
   input  logic             dec_ready,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] fifo_count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [31:0]      pc_mem_q    [DEPTH];
   logic [31:0]      instr_mem_q [DEPTH];

   logic             full;
   logic             pop;
   logic             push;
   logic [31:0]      redirect_target;

   // Decode handshake: the head transfers on a cycle where if_valid and
   // dec_ready are both high; if_instr/if_pc stay stable while dec_ready is low.
   assign full            = (count_q == CNT_W'(DEPTH));
   assign if_valid        = (count_q != '0);
   assign pop             = if_valid & dec_ready;
   assign imem_req        = rst_n & ~redirect_valid & (~full | pop);
   assign push            = imem_req & imem_gnt;
   assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

   assign imem_addr  = fetch_pc_q;
   assign fifo_count = count_q;
   assign if_instr   = if_valid ? instr_mem_q[rd_ptr_q] : NOP;
   assign if_pc      = if_valid ? pc_mem_q[rd_ptr_q]    : 32'h0000_0000;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect_valid) begin
         // A pop in the same cycle is dropped; decode squashes what it sampled.
         fetch_pc_d = redirect_target;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Payload storage needs no reset: entries are only visible below count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CNT_W'(DEPTH));
   a_addr_aligned : assert property (@(posedge clk) disable iff (!rst_n)
      imem_addr[1:0] == 2'b00);
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop));

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the combinational instruction memory for the pipeline's IF stage.
- Owns the fetch PC and drives the memory address.
- Requests the memory port from a shared-port arbiter and buffers fetched words in a small prefetch FIFO.
- Presents {pc, instruction} to decode with a valid/ready handshake; a branch/jump redirect flushes the FIFO and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset (bits [1:0] must be 0).
- DEPTH, 4, prefetch FIFO entries (power of two, 2..16).
- CNT_W, 3, width of the occupancy count (log2(DEPTH)+1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_addr  output  32  byte address to instruction memory; equals fetch_pc.
- imem_rdata  input  32  instruction word returned combinationally for imem_addr.
- imem_req  output  1  request for the memory port this cycle.
- imem_gnt  input  1  port granted this cycle; imem_rdata is valid only when imem_gnt=1.
- if_valid  output  1  FIFO head holds a valid instruction.
- if_instr  output  32  instruction at FIFO head; 32'h0000_0013 (nop) when empty.
- if_pc  output  32  PC of the FIFO head; 0 when empty.
- dec_ready  input  1  decode accepts the head this cycle (active-high; low = stall).
- redirect_valid  input  1  branch/jump taken; flush and refetch.
- redirect_pc  input  32  target; bits [1:0] are ignored (forced to 0).
- fifo_count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; FIFO read pointer, write pointer and count=0.
  - if_valid=0, if_instr=nop, if_pc=0, imem_req=0 while in reset, fifo_count=0.
- Definitions:
  - pop = if_valid & dec_ready.
  - full = (count==DEPTH).
- imem_req:
  - Combinational: imem_req = rst_n & ~redirect_valid & (~full | pop).
- push:
  - push = imem_req & imem_gnt.
  - On push at a rising edge, entry {fetch_pc, imem_rdata} is written at the write pointer and fetch_pc += 4.
  - fetch_pc is a 32-bit add; 32'hFFFF_FFFC wraps to 0.
- No grant: imem_gnt=0 means no push and fetch_pc holds. There is no timeout.
- Outputs from FIFO head:
  - if_valid = (count!=0).
  - if_instr and if_pc are taken combinationally from the head entry, with the empty-state values applied when count==0.
- Pop: advances the read pointer. Pointers wrap modulo DEPTH.
- Count update:
  - push & ~pop: +1.
  - pop & ~push: -1.
  - both or neither: unchanged.
- Full: simultaneous push and pop is allowed, so throughput stays 1 instr/cycle at full occupancy.
- Empty: pop is impossible because if_valid=0. The push lands and is visible at the head on the next cycle.
- Redirect (priority over everything):
  - When redirect_valid=1 at an edge: count, read pointer and write pointer go to 0, and fetch_pc={redirect_pc[31:2],2'b00}.
  - There is no push that cycle (imem_req=0).
  - A pop coincident with redirect is ignored for buffer state. Decode owns the squash of anything it sampled.
- Redirect latency:
  - Redirect sampled at edge k: imem_addr=target during cycle k+1.
  - With imem_gnt=1, if_valid=1 with if_pc=target after edge k+1.
  - Back-to-back redirects: the last one wins, and each flushes the FIFO again.
- Steady-state latency: with the FIFO empty and dec_ready=1, an instruction fetched at edge n appears at the head in cycle n+1.
- Ordering: no reordering or duplication. Every pushed entry is popped exactly once unless flushed.
- Reset mid-operation: asserting rst_n low at any time immediately clears state asynchronously and drops if_valid. After release, fetch resumes at RESET_PC on the first edge with grant.
- Invariants:
  - 0 <= count <= DEPTH; push never occurs when full & ~pop.
  - imem_addr[1:0]==2'b00 always.

Test Plan:
- Reset then imem_gnt=1, dec_ready=1, memory word[i]=32'h1000_0000+i:
  - if_pc sequence is 0,4,8,...
  - if_instr is 0x1000_0000, 0x1000_0001, ...
  - if_valid is continuous from the second cycle after reset release.
- Stall: dec_ready=0 for 10 cycles with DEPTH=4:
  - fifo_count saturates at 4 and imem_req drops to 0.
  - imem_addr holds at 16; head stays pc=0.
  - On release, the sequence continues 0,4,8,12,16 with no gaps or duplicates.
- Redirect with redirect_pc=32'h0000_0043 while the FIFO holds 3 entries:
  - Next cycle fifo_count=0, if_valid=0, imem_addr=0x40.
  - The following cycle if_pc=0x40.
- Grant starvation: imem_gnt toggles 1,0,0,1 with dec_ready=1:
  - Pushes occur only on granted cycles.
  - fetch_pc advances by 4 only on those cycles; the if_valid bubbles match.
- Full with simultaneous push/pop at DEPTH=4, count=4:
  - dec_ready=1 and imem_gnt=1 keep count at 4 and deliver one instruction per cycle.
  - Redirect plus pop in the same cycle leaves count=0.
- Wrap and async reset:
  - redirect_pc=32'hFFFF_FFF8 yields if_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Pulsing rst_n low mid-stream clears if_valid immediately, and fetch restarts at RESET_PC.
